// File: rtl/chargen_src_pkg.sv
// rtl/chargen_src_pkg.sv - shared constants and index helper for the character generator
package chargen_src_pkg;

  // Active-low flag levels: N_TRUE means the flag is asserted.
  localparam logic N_TRUE  = 1'b0;
  localparam logic N_FALSE = 1'b1;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_BANG  = 8'h21;
  localparam logic [7:0] ASCII_TILDE = 8'h7E;

  // Increment a character index and wrap to 0 when it reaches the set size.
  function automatic logic [6:0] wrap_inc(input logic [6:0] v, input logic [6:0] n);
    logic [6:0] nxt;
    nxt = v + 7'd1;
    return (nxt == n) ? 7'd0 : nxt;
  endfunction

endpackage

// File: rtl/chargen_src_if.sv
// rtl/chargen_src_if.sv - FIFO write-side bundle between the generator and the FIFO
interface chargen_src_if;
  logic       n_full;
  logic       n_wr;
  logic [7:0] port_out;
  logic       line_done;

  modport master (input n_full, output n_wr, output port_out, output line_done);
  modport slave  (output n_full, input n_wr, input port_out, input line_done);
endinterface

// File: rtl/chargen_pattern.sv
// rtl/chargen_pattern.sv - line/column position tracker producing the current byte
module chargen_pattern
  import chargen_src_pkg::*;
#(
  parameter int         LINE_LEN   = 72,
  parameter logic [7:0] FIRST_CHAR = ASCII_BANG,
  parameter logic [7:0] LAST_CHAR  = ASCII_TILDE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       advance,
  output logic [7:0] char,
  output logic       is_lf
);

  localparam logic [6:0] NCHARS = 7'(LAST_CHAR - FIRST_CHAR + 8'd1);
  localparam logic [7:0] COL_CR = 8'(LINE_LEN);
  localparam logic [7:0] COL_LF = 8'(LINE_LEN + 1);

  logic [6:0] line_base;
  logic [6:0] idx;
  logic [7:0] col;

  // Step one position per advance; after LF restart the line one character later.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_base <= 7'd0;
      idx       <= 7'd0;
      col       <= 8'd0;
    end else if (advance) begin
      if (col == COL_LF) begin
        col       <= 8'd0;
        line_base <= wrap_inc(line_base, NCHARS);
        idx       <= wrap_inc(line_base, NCHARS);
      end else begin
        col <= col + 8'd1;
        if (col < COL_CR) begin
          idx <= wrap_inc(idx, NCHARS);
        end
      end
    end
  end

  // Map the current position to its byte value.
  always_comb begin
    char  = FIRST_CHAR + {1'b0, idx};
    is_lf = 1'b0;
    if (col == COL_CR) begin
      char = ASCII_CR;
    end else if (col == COL_LF) begin
      char  = ASCII_LF;
      is_lf = 1'b1;
    end
  end

endmodule

// File: rtl/chargen_src.sv
// rtl/chargen_src.sv - three-cycle-per-byte FIFO writer for the rotating character stream
module chargen_src
  import chargen_src_pkg::*;
#(
  parameter int         LINE_LEN   = 72,
  parameter logic [7:0] FIRST_CHAR = ASCII_BANG,
  parameter logic [7:0] LAST_CHAR  = ASCII_TILDE
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  chargen_src_if.master fifo
);

  typedef enum logic [1:0] {
    SETUP = 2'd0,
    STB   = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] next_char;
  logic       next_is_lf;
  logic       advance;

  // The pattern moves on while the strobe is low, so during HOLD it already
  // presents the following byte, ready to load into port_out on the HOLD edge.
  assign advance = (state == STB);

  chargen_pattern #(
    .LINE_LEN  (LINE_LEN),
    .FIRST_CHAR(FIRST_CHAR),
    .LAST_CHAR (LAST_CHAR)
  ) u_pattern (
    .clk    (clk),
    .rst    (rst),
    .advance(advance),
    .char   (next_char),
    .is_lf  (next_is_lf)
  );

  // SETUP/STB/HOLD sequencer with registered strobe, data and line pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= SETUP;
      fifo.n_wr      <= N_FALSE;
      fifo.port_out  <= FIRST_CHAR;
      fifo.line_done <= 1'b0;
    end else begin
      case (state)
        SETUP: begin
          fifo.line_done <= 1'b0;
          if (en && (fifo.n_full == N_FALSE)) begin
            state     <= STB;
            fifo.n_wr <= N_TRUE;
          end else begin
            fifo.n_wr <= N_FALSE;
          end
        end
        STB: begin
          state          <= HOLD;
          fifo.n_wr      <= N_FALSE;
          fifo.line_done <= next_is_lf;
        end
        HOLD: begin
          state          <= SETUP;
          fifo.n_wr      <= N_FALSE;
          fifo.port_out  <= next_char;
          fifo.line_done <= 1'b0;
        end
        default: begin
          state          <= SETUP;
          fifo.n_wr      <= N_FALSE;
          fifo.line_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chargen_src.sv
// tb/tb_chargen_src.sv - directed self-checking bench for chargen_src
module tb_chargen_src;

  localparam int NCH  = 8'h7E - 8'h21 + 1;
  localparam int L72W = 72 + 2;

  typedef struct {
    logic       r;
    logic       e;
    logic       nf;
    logic       x_nwr;
    logic [7:0] x_port;
    logic       x_ld;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst4 = 1'b1, en4 = 1'b0, nf4_drv = 1'b1, fifo_mode = 1'b0;
  logic rst72 = 1'b1, en72 = 1'b0, nf72 = 1'b1;
  int   push_cnt = 0;
  int   pop_cnt = 0;

  chargen_src_if if4 ();
  chargen_src_if if72 ();

  assign if4.n_full  = fifo_mode ? ((push_cnt - pop_cnt) != 4) : nf4_drv;
  assign if72.n_full = nf72;

  chargen_src #(.LINE_LEN(4)) d4 (
    .clk (clk),
    .rst (rst4),
    .en  (en4),
    .fifo(if4.master)
  );

  chargen_src #(.LINE_LEN(72)) d72 (
    .clk (clk),
    .rst (rst72),
    .en  (en72),
    .fifo(if72.master)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [7:0] cap4[$];
  logic [7:0] cap72[$];
  int strobe_t4[$];
  int ld4 = 0, ld72 = 0;
  logic plf4 = 1'b0, plf72 = 1'b0;
  vec_t vt[27];

  function automatic logic [7:0] model_byte(int ll, int n);
    int k, i;
    k = n / (ll + 2);
    i = n % (ll + 2);
    if (i < ll) return 8'(8'h21 + ((k + i) % NCH));
    else if (i == ll) return 8'h0D;
    else return 8'h0A;
  endfunction

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Byte capture and line_done alignment: a pulse must follow an LF strobe by one cycle.
  always @(negedge clk) begin
    cyc++;
    if (!if4.n_wr) begin
      cap4.push_back(if4.port_out);
      strobe_t4.push_back(cyc);
    end
    if (if4.line_done || plf4) check("ld_align4", int'(if4.line_done), int'(plf4));
    if (if4.line_done) ld4++;
    plf4 = !if4.n_wr && (if4.port_out == 8'h0A);
    if (!if72.n_wr) cap72.push_back(if72.port_out);
    if (if72.line_done || plf72) check("ld_align72", int'(if72.line_done), int'(plf72));
    if (if72.line_done) ld72++;
    plf72 = !if72.n_wr && (if72.port_out == 8'h0A);
  end

  // Depth-4 FIFO occupancy model for the backpressure test.
  always @(posedge clk) begin
    if (fifo_mode && !rst4 && !if4.n_wr) begin
      check("no_overflow", int'((push_cnt - pop_cnt) < 4), 1);
      push_cnt <= push_cnt + 1;
    end
  end

  initial begin
    int base, mism, n;

    vt[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h21, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h21, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h21, 1'b0};
    vt[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h21, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h21, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h21, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h22, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h23, 1'b0};
    vt[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h23, 1'b0};
    vt[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h23, 1'b0};
    vt[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h23, 1'b0};
    vt[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h24, 1'b0};
    vt[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h24, 1'b0};
    vt[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h24, 1'b0};
    vt[16] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h24, 1'b0};
    vt[17] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h0D, 1'b0};
    vt[18] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h0D, 1'b0};
    vt[19] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h0D, 1'b0};
    vt[20] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h0A, 1'b0};
    vt[21] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h0A, 1'b0};
    vt[22] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h0A, 1'b1};
    vt[23] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0};
    vt[24] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h22, 1'b0};
    vt[25] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h21, 1'b0};
    vt[26] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h21, 1'b0};

    // Reset state and idle with en low
    step();
    rst4 = 1'b1; en4 = 1'b0;
    steps(2);
    check("rst_nwr", int'(if4.n_wr), 1);
    check("rst_port", int'(if4.port_out), 8'h21);
    check("rst_ld", int'(if4.line_done), 0);
    rst4 = 1'b0;
    cap4.delete();
    steps(10);
    check("idle_no_strobe", cap4.size(), 0);
    check("idle_port", int'(if4.port_out), 8'h21);

    // Cycle-by-cycle vector table
    for (int i = 0; i < 27; i++) begin
      rst4 = vt[i].r; en4 = vt[i].e; nf4_drv = vt[i].nf;
      step();
      check($sformatf("vec%0d", i), int'({if4.n_wr, if4.port_out, if4.line_done}),
            int'({vt[i].x_nwr, vt[i].x_port, vt[i].x_ld}));
    end

    // Basic push, two lines of LINE_LEN=4
    en4 = 1'b0; rst4 = 1'b1; steps(2); rst4 = 1'b0;
    cap4.delete(); strobe_t4.delete(); base = ld4;
    en4 = 1'b1; nf4_drv = 1'b1;
    n = 0;
    while (cap4.size() < 12 && n < 200) begin step(); n++; end
    check("push_timeout", int'(cap4.size() >= 12), 1);
    if (cap4.size() >= 12) begin
      for (int i = 0; i < 12; i++) check($sformatf("push%0d", i), int'(cap4[i]), int'(model_byte(4, i)));
      for (int i = 1; i < 12; i++) check($sformatf("spacing%0d", i), strobe_t4[i] - strobe_t4[i-1], 3);
    end
    steps(2);
    check("push_ld_count", ld4 - base, 2);
    en4 = 1'b0;

    // Backpressure against a depth-4 FIFO
    rst4 = 1'b1; steps(2); rst4 = 1'b0;
    cap4.delete();
    pop_cnt = push_cnt;
    fifo_mode = 1'b1; en4 = 1'b1;
    steps(60);
    check("bp_strobes_full", cap4.size(), 4);
    check("bp_nwr_parked", int'(if4.n_wr), 1);
    check("bp_full_flag", int'(if4.n_full), 0);
    pop_cnt = pop_cnt + 3;
    steps(60);
    check("bp_strobes_after_pop", cap4.size(), 7);
    if (cap4.size() >= 7)
      for (int i = 0; i < 7; i++) check($sformatf("bp%0d", i), int'(cap4[i]), int'(model_byte(4, i)));
    fifo_mode = 1'b0; en4 = 1'b0;
    step();

    // Pause: drop en during the strobe of byte 3
    rst4 = 1'b1; steps(2); rst4 = 1'b0;
    cap4.delete(); en4 = 1'b1;
    n = 0;
    while (cap4.size() < 4 && n < 100) begin step(); n++; end
    check("pause_reach", cap4.size(), 4);
    en4 = 1'b0;
    steps(20);
    check("pause_no_more", cap4.size(), 4);
    check("pause_nwr", int'(if4.n_wr), 1);
    en4 = 1'b1;
    n = 0;
    while (cap4.size() < 6 && n < 100) begin step(); n++; end
    check("resume_reach", cap4.size(), 6);
    if (cap4.size() >= 6)
      for (int i = 0; i < 6; i++) check($sformatf("pause%0d", i), int'(cap4[i]), int'(model_byte(4, i)));
    en4 = 1'b0;

    // Wrap over 96 lines of 72 characters
    rst72 = 1'b1; steps(2); rst72 = 1'b0;
    cap72.delete(); base = ld72;
    en72 = 1'b1; nf72 = 1'b1;
    n = 0;
    while (cap72.size() < 96 * L72W && n < 22000) begin step(); n++; end
    check("wrap_timeout", int'(cap72.size() >= 96 * L72W), 1);
    step();
    en72 = 1'b0;
    if (cap72.size() >= 96 * L72W) begin
      mism = 0;
      for (int i = 0; i < 96 * L72W; i++) if (cap72[i] != model_byte(72, i)) mism++;
      check("wrap_stream_errs", mism, 0);
      check("wrap_last_line_first", int'(cap72[(NCH - 1) * L72W]), 8'h7E);
      check("wrap_last_line_second", int'(cap72[(NCH - 1) * L72W + 1]), 8'h21);
      mism = 0;
      for (int i = 0; i < L72W; i++) if (cap72[NCH * L72W + i] != cap72[i]) mism++;
      check("wrap_repeat_line0", mism, 0);
      mism = 0;
      for (int i = 0; i < L72W; i++) if (cap72[(NCH + 1) * L72W + i] != cap72[L72W + i]) mism++;
      check("wrap_repeat_line1", mism, 0);
    end
    check("wrap_ld_count", ld72 - base, 96);
    steps(4);

    // Reset during the strobe of the first byte of line 2
    rst72 = 1'b1; steps(2); rst72 = 1'b0;
    cap72.delete(); en72 = 1'b1;
    n = 0;
    while (cap72.size() < 2 * L72W + 1 && n < 1000) begin step(); n++; end
    check("mid_reach", cap72.size(), 2 * L72W + 1);
    check("mid_in_strobe", int'(if72.n_wr), 0);
    rst72 = 1'b1;
    step();
    check("mid_abort_nwr", int'(if72.n_wr), 1);
    check("mid_abort_port", int'(if72.port_out), 8'h21);
    rst72 = 1'b0;
    cap72.delete(); base = ld72;
    n = 0;
    while (cap72.size() < L72W && n < 400) begin step(); n++; end
    check("post_rst_reach", cap72.size(), L72W);
    check("post_rst_no_ld", ld72 - base, 0);
    step();
    check("post_rst_ld", ld72 - base, 1);
    if (cap72.size() >= L72W) begin
      check("post_rst_first", int'(cap72[0]), 8'h21);
      mism = 0;
      for (int i = 0; i < L72W; i++) if (cap72[i] != model_byte(72, i)) mism++;
      check("post_rst_line", mism, 0);
    end
    en72 = 1'b0;
    steps(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
